// File: rtl/lisp_io_bridge_if.sv
// Signal bundle for lisp_io_bridge: core data port, data RAM port and peripheral channels.
// slave  : the bridge's own view of the bundle.
// master : the surrounding system's view (core, RAM and peripherals drive/observe the bridge).
interface lisp_io_bridge_if #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 19,
  parameter int NUM_CHANNELS   = 4,
  parameter int CHAN_ADDR_BITS = 10
);
  logic [ADDR_WIDTH-1:0]      core_addr;
  logic [DATA_WIDTH-1:0]      core_write_value;
  logic                       core_write_en;
  logic [DATA_WIDTH-1:0]      core_read_value;
  logic                       core_stall;
  logic                       mem_write_en;
  logic [DATA_WIDTH-1:0]      mem_read_value;
  logic [CHAN_ADDR_BITS-1:0]  io_index;
  logic [15:0]                io_write_value;
  logic [NUM_CHANNELS-1:0]    io_read;
  logic [NUM_CHANNELS-1:0]    io_write;
  logic [16*NUM_CHANNELS-1:0] io_read_value;
  logic [NUM_CHANNELS-1:0]    io_ready;
  logic                       io_timeout;

  modport slave (
    input  core_addr, core_write_value, core_write_en, mem_read_value, io_read_value, io_ready,
    output core_read_value, core_stall, mem_write_en, io_index, io_write_value, io_read, io_write,
           io_timeout
  );

  modport master (
    output core_addr, core_write_value, core_write_en, mem_read_value, io_read_value, io_ready,
    input  core_read_value, core_stall, mem_write_en, io_index, io_write_value, io_read, io_write,
           io_timeout
  );
endinterface

// File: rtl/lisp_io_bridge.sv
// lisp_io_bridge: routes the lisp_core data port either to data RAM or to one of NUM_CHANNELS
// peripheral channels (top address nibble == IO_PREFIX). Peripherals may hold off completion
// with io_ready; the core is stalled meanwhile and a hung access is forced to complete after
// TIMEOUT_CYCLES wait cycles (0 disables the timeout). Read data returns one cycle after
// completion, matching the RAM's latency.
// Optional feature: define IO_STATUS_REG_EN to turn address {IO_PREFIX, all ones} into a
// bridge-internal status register (timeout flag, last timed-out channel, saturating count).
module lisp_io_bridge #(
  parameter int         ADDR_WIDTH     = 16,
  parameter int         DATA_WIDTH     = 19,
  parameter int         NUM_CHANNELS   = 4,
  parameter int         CHAN_ADDR_BITS = 10,
  parameter logic [3:0] IO_PREFIX      = 4'hF,
  parameter int         TIMEOUT_CYCLES = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  lisp_io_bridge_if.slave bus
);
  // Channel number sits between the prefix nibble and the register index.
  localparam int CHAN_W = ADDR_WIDTH - 4 - CHAN_ADDR_BITS;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]      CNT_LIMIT     = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] TIMEOUT_VALUE = DATA_WIDTH'(17'h0FFFF);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          wait_cnt_q;
  logic [CHAN_W-1:0]         cap_chan_q;
  logic                      cap_we_q;
  logic [CHAN_ADDR_BITS-1:0] cap_index_q;
  logic [15:0]               cap_wdata_q;
  logic [DATA_WIDTH-1:0]     rd_latch_q;
  logic                      io_path_q;
  logic                      io_timeout_q;

  logic                      is_io;
  logic                      is_status;
  logic [CHAN_W-1:0]         dec_chan;
  logic                      chan_ok;

  logic [CHAN_W-1:0]         act_chan;
  logic                      act_we;
  logic                      act_ok;
  logic [NUM_CHANNELS-1:0]   act_onehot;
  logic                      act_ready;
  logic [15:0]               act_rdata;

  logic                      complete;
  logic                      force_done;
  logic                      capture;
  logic                      stall;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     complete_value;

  // Upper tag bits of the write word never reach a peripheral.
  logic                      unused_wval_hi;
  assign unused_wval_hi = ^bus.core_write_value[DATA_WIDTH-1:16];

  assign is_io    = (bus.core_addr[ADDR_WIDTH-1 -: 4] == IO_PREFIX);
  assign dec_chan = bus.core_addr[CHAN_ADDR_BITS +: CHAN_W];
  assign chan_ok  = (int'(dec_chan) < NUM_CHANNELS);

`ifdef IO_STATUS_REG_EN
  assign is_status = is_io && (&bus.core_addr[ADDR_WIDTH-5:0]);
`else
  assign is_status = 1'b0;
`endif

  // While waiting, everything seen by the peripheral comes from the captured copy.
  assign act_chan   = (state_q == S_WAIT) ? cap_chan_q : dec_chan;
  assign act_we     = (state_q == S_WAIT) ? cap_we_q   : bus.core_write_en;
  assign act_ok     = (state_q == S_WAIT) || (is_io && !is_status && chan_ok);
  assign act_onehot = act_ok ? (NUM_CHANNELS'(1) << act_chan) : '0;
  assign act_ready  = |(bus.io_ready & act_onehot);

  // Select the addressed channel's read data (zero when no channel is addressed).
  always_comb begin
    act_rdata = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (act_onehot[c]) act_rdata = act_rdata | bus.io_read_value[16*c +: 16];
    end
  end

  // Next-state, stall and completion decisions.
  always_comb begin
    state_d    = state_q;
    complete   = 1'b0;
    force_done = 1'b0;
    capture    = 1'b0;
    stall      = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!is_io) begin
          mem_we = bus.core_write_en;
        end else if (is_status || !chan_ok || act_ready) begin
          complete = 1'b1;
        end else begin
          stall   = 1'b1;
          capture = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (act_ready) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == CNT_LIMIT)) begin
          force_done = 1'b1;
          state_d    = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef IO_STATUS_REG_EN
  logic       status_wr;
  logic [3:0] to_chan_q;
  logic [3:0] to_count_q;

  assign status_wr = (state_q == S_IDLE) && is_status && bus.core_write_en;

  // Timeout history: last channel that hung and a saturating count, cleared by a status write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_chan_q  <= '0;
      to_count_q <= '0;
    end else if (force_done) begin
      to_chan_q <= 4'(cap_chan_q);
      if (to_count_q != 4'hF) to_count_q <= to_count_q + 4'd1;
    end else if (status_wr) begin
      to_chan_q  <= '0;
      to_count_q <= '0;
    end
  end

  // Value latched on completion: status word for the status address, else channel data.
  always_comb begin
    complete_value = DATA_WIDTH'(act_rdata);
    if (is_status && (state_q == S_IDLE))
      complete_value = DATA_WIDTH'({io_timeout_q, 7'b0, to_chan_q, to_count_q});
  end
`else
  // Value latched on completion: the addressed channel's data.
  always_comb begin
    complete_value = DATA_WIDTH'(act_rdata);
  end
`endif

  // Control state: FSM, wait counter, captured channel/direction, read latch, sticky timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      cap_chan_q   <= '0;
      cap_we_q     <= 1'b0;
      rd_latch_q   <= '0;
      io_path_q    <= 1'b0;
      io_timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      io_path_q <= complete | force_done;
      if (capture) begin
        cap_chan_q <= dec_chan;
        cap_we_q   <= bus.core_write_en;
        wait_cnt_q <= CNT_W'(1);
      end else if ((state_q == S_WAIT) && (TIMEOUT_CYCLES != 0) && (wait_cnt_q != CNT_LIMIT)) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
      if (complete)        rd_latch_q <= complete_value;
      else if (force_done) rd_latch_q <= TIMEOUT_VALUE;
      if (force_done) io_timeout_q <= 1'b1;
`ifdef IO_STATUS_REG_EN
      else if (status_wr) io_timeout_q <= 1'b0;
`endif
    end
  end

  // Captured register index and write data presented to the peripheral while waiting.
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_index_q <= bus.core_addr[CHAN_ADDR_BITS-1:0];
      cap_wdata_q <= bus.core_write_value[15:0];
    end
  end

  // Strobes, stall and RAM write are forced low the moment reset is asserted.
  assign bus.core_stall      = stall & reset_n;
  assign bus.mem_write_en    = mem_we & reset_n;
  assign bus.io_read         = act_onehot & {NUM_CHANNELS{!act_we && reset_n}};
  assign bus.io_write        = act_onehot & {NUM_CHANNELS{act_we && reset_n}};
  assign bus.io_index        = (state_q == S_WAIT) ? cap_index_q : bus.core_addr[CHAN_ADDR_BITS-1:0];
  assign bus.io_write_value  = (state_q == S_WAIT) ? cap_wdata_q : bus.core_write_value[15:0];
  assign bus.core_read_value = io_path_q ? rd_latch_q : bus.mem_read_value;
  assign bus.io_timeout      = io_timeout_q;

endmodule

// File: tb/tb_lisp_io_bridge.sv
// Self-checking bench for lisp_io_bridge (default build, status register disabled).
`timescale 1ns/1ps
module tb_lisp_io_bridge;
  localparam int AW  = 16;
  localparam int DW  = 19;
  localparam int NC  = 4;
  localparam int CAB = 10;
  localparam int TO  = 15;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  lisp_io_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .CHAN_ADDR_BITS(CAB)) bus ();

  lisp_io_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .CHAN_ADDR_BITS(CAB),
    .IO_PREFIX(4'hF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] ram [logic [AW-1:0]];
  bit            prev_valid = 1'b0;
  bit            prev_ram   = 1'b0;
  logic [DW-1:0] prev_exp   = '0;
  bit            exp_to     = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One core access; delay = cycles the addressed channel holds io_ready low.
  task automatic access(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wdata,
                        input int delay, input logic [15:0] rdat);
    bit               io;
    int               ch;
    int               exp_stall;
    int               waited;
    logic [NC-1:0]    exp_strobe;
    logic [NC-1:0]    rdy;
    logic [16*NC-1:0] iv;
    io         = (addr[AW-1 -: 4] == 4'hF);
    ch         = int'(addr[CAB +: 2]);
    exp_stall  = !io ? 0 : ((delay < TO) ? delay : TO);
    exp_strobe = io ? (NC'(1) << ch) : NC'(0);
    iv         = {$urandom, $urandom};
    if (io) iv[16*ch +: 16] = rdat;
    rdy = io ? {NC{1'b1}} : NC'($urandom);
    if (io) rdy[ch] = (delay == 0);

    @(negedge clk);
    bus.core_addr        = addr;
    bus.core_write_value = wdata;
    bus.core_write_en    = we;
    bus.io_read_value    = iv;
    bus.io_ready         = rdy;
    bus.mem_read_value   = prev_ram ? prev_exp : DW'($urandom);
    #1;
    if (prev_valid) check("rdata", 64'(bus.core_read_value), 64'(prev_exp));
    check("io_timeout", 64'(bus.io_timeout), 64'(exp_to));
    check("io_index", 64'(bus.io_index), 64'(addr[CAB-1:0]));
    check("io_wval", 64'(bus.io_write_value), 64'(wdata[15:0]));
    check("io_read", 64'(bus.io_read), 64'(we ? NC'(0) : exp_strobe));
    check("io_write", 64'(bus.io_write), 64'(we ? exp_strobe : NC'(0)));

    waited = 0;
    while ((bus.core_stall === 1'b1) && (waited <= 40)) begin
      check("mem_we_wait", 64'(bus.mem_write_en), 64'(0));
      check("strobe_held", 64'({bus.io_write, bus.io_read}),
            64'(we ? {exp_strobe, NC'(0)} : {NC'(0), exp_strobe}));
      waited++;
      @(negedge clk);
      if (io) begin
        rdy[ch]      = (waited >= delay);
        bus.io_ready = rdy;
      end
      #1;
    end
    if (waited > 40) begin
      total++;
      bad++;
      $error("FAIL stall_bound got=%0d exp<=%0d", waited, TO);
    end
    check("stall_cycles", 64'(waited), 64'(exp_stall));
    check("mem_we", 64'(bus.mem_write_en), 64'(!io && we));

    prev_valid = 1'b0;
    prev_ram   = 1'b0;
    if (!io && we) ram[addr] = wdata;
    if (!io && !we) begin
      prev_valid = 1'b1;
      prev_ram   = 1'b1;
      prev_exp   = ram.exists(addr) ? ram[addr] : '0;
    end
    if (io && !we) begin
      prev_valid = 1'b1;
      prev_exp   = (delay <= TO) ? DW'(rdat) : 19'h0FFFF;
    end
    if (io && (delay > TO)) exp_to = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with an I/O read presented during reset
    reset_n              = 1'b0;
    bus.core_addr        = 16'hF405;
    bus.core_write_value = '0;
    bus.core_write_en    = 1'b0;
    bus.mem_read_value   = 19'h12345;
    bus.io_read_value    = '0;
    bus.io_ready         = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 64'(bus.core_stall), 64'(0));
    check("rst_io_read", 64'(bus.io_read), 64'(0));
    check("rst_io_write", 64'(bus.io_write), 64'(0));
    check("rst_timeout", 64'(bus.io_timeout), 64'(0));
    check("rst_mem_we", 64'(bus.mem_write_en), 64'(0));
    @(negedge clk);
    reset_n       = 1'b1;
    bus.core_addr = 16'h0100;
    #1;
    check("rst_rdata_path", 64'(bus.core_read_value), 64'(19'h12345));

    // Directed cases
    access(16'h0123, 1'b1, 19'h1ABCD, 0, 16'h0);
    access(16'h0123, 1'b0, 19'h0, 0, 16'h0);
    access(16'hF405, 1'b0, 19'h0, 0, 16'hBEEF);
    access(16'hF810, 1'b1, 19'h05A5A, 3, 16'h0);
    access(16'hFC00, 1'b0, 19'h0, 1000, 16'h1111);
    access(16'h0040, 1'b0, 19'h0, 0, 16'h0);

    // Reset asserted while an I/O write is waiting
    @(negedge clk);
    bus.core_addr        = 16'hF810;
    bus.core_write_en    = 1'b1;
    bus.core_write_value = 19'h00777;
    bus.io_ready         = 4'b1011;
    #1;
    check("rw_stall_start", 64'(bus.core_stall), 64'(1));
    repeat (2) @(negedge clk);
    #1;
    check("rw_stall_wait", 64'(bus.core_stall), 64'(1));
    check("rw_strobe_wait", 64'(bus.io_write), 64'(4'b0100));
    #2;
    reset_n = 1'b0;
    #1;
    check("rw_stall_drop", 64'(bus.core_stall), 64'(0));
    check("rw_write_drop", 64'(bus.io_write), 64'(0));
    check("rw_read_drop", 64'(bus.io_read), 64'(0));
    check("rw_timeout_clr", 64'(bus.io_timeout), 64'(0));
    exp_to     = 1'b0;
    prev_valid = 1'b0;
    prev_ram   = 1'b0;
    @(negedge clk);
    bus.core_addr     = 16'h0200;
    bus.core_write_en = 1'b0;
    reset_n           = 1'b1;
    access(16'hF810, 1'b1, 19'h01234, 2, 16'h0);
    access(16'hF404, 1'b0, 19'h0, 0, 16'h4321);
    access(16'h0010, 1'b0, 19'h0, 0, 16'h0);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] a;
      int            d;
      if ($urandom_range(0, 1) == 1) a = {4'hF, 12'($urandom)};
      else                           a = {4'h0, 8'h00, 4'($urandom_range(0, 7))};
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 25)) : int'($urandom_range(0, 3));
      access(a, 1'($urandom), DW'($urandom), d, 16'($urandom));
    end
    access(16'h0000, 1'b0, 19'h0, 0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
